// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants for the MIPS core.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } pipe_state_e;

  localparam int unsigned DEFAULT_CNT_W = 2;
  localparam int unsigned PERF_W        = 32;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating stall-cycle and branch-squash counters for pipe_hold_ctrl.
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_inc,
  input  logic              flush_inc,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  logic [PERF_W-1:0] stall_q, stall_d;
  logic [PERF_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (flush_inc && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: boot hold, hazard bubbles, branch squash, memory freeze.
// Define STALL_PERF_EN to build the stall/flush performance counters.
module pipe_hold_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 1,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hazard_req,
  input  logic [CNT_W-1:0]  hazard_cycles,
  input  logic              branch_flush,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              stall_active,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

  pipe_state_e      state_q, state_d;
  logic [3:0]       boot_q, boot_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] hold_init;

  // Extra HOLD cycles after the RUN cycle that accepts the hazard; a count of 0 acts as 1.
  assign hold_init = (hazard_cycles == '0) ? '0 : hazard_cycles - CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    boot_d     = boot_q;
    hold_d     = hold_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;

    if (mem_busy) begin
      // Whole-pipe freeze: nothing loads and no state advances.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (boot_q == BootLast) begin
            state_d = StRun;
            boot_d  = '0;
          end else begin
            boot_d = boot_q + 4'd1;
          end
        end
        StRun: begin
          if (hazard_req) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (hold_init != '0) begin
              state_d = StHold;
              hold_d  = hold_init;
            end
          end else if (branch_flush) begin
            ifid_flush = 1'b1;
          end
        end
        StHold: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          hold_d     = hold_q - CNT_W'(1);
          if (hold_q == CNT_W'(1)) state_d = StRun;
        end
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
      boot_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      hold_q  <= hold_d;
    end
  end

  assign stall_active = (state_q != StRun) | mem_busy | (hazard_req & (state_q == StRun));

`ifdef STALL_PERF_EN
  logic branch_applied;
  assign branch_applied = (state_q == StRun) & ~mem_busy & ~hazard_req & branch_flush;

  pipe_ctrl_perf u_perf (
    .clock        (clock),
    .reset        (reset),
    .stall_inc    (~pc_en),
    .flush_inc    (branch_applied),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
